// File: rtl/axi_master_lite_if.sv
// AXI4-Lite bus bundle between axi_master_lite and its slave.
// The master modport is the view taken by the master; the slave modport is the mirror image.
interface axi_master_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_master_lite.sv
// AXI4-Lite single-outstanding master: one command in, one AXI transaction out, one response back.
// Define AXI_MST_TIMEOUT_EN to build a watchdog that aborts a stalled transaction after TIMEOUT_CYCLES.
module axi_master_lite #(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           STRB_WIDTH     = DATA_WIDTH / 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'hFFFF_0000),
   parameter int unsigned           TIMEOUT_CYCLES = 256
) (
   input  logic                  aclk,
   input  logic                  arst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   axi_master_lite_if.master     axi
);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      RSP
   } state_t;

   state_t                state;
   logic                  aw_valid_q;
   logic                  w_valid_q;
   logic                  b_ready_q;
   logic                  ar_valid_q;
   logic                  r_ready_q;
   logic                  aw_done;
   logic                  w_done;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  tmo_hit;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axi_master_lite: TIMEOUT_CYCLES must be at least 1");
   end

   // Every bus output comes straight from a flop, so nothing depends combinationally on a ready.
   assign axi.awvalid = aw_valid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.wvalid  = w_valid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.bready  = b_ready_q;
   assign axi.arvalid = ar_valid_q;
   assign axi.araddr  = araddr_q;
   assign axi.rready  = r_ready_q;

`ifdef AXI_MST_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state_d;
   logic             busy;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_elapsed;

   assign busy        = (state == WR_REQ) || (state == WR_RESP) ||
                        (state == RD_REQ) || (state == RD_DATA);
   // A state differing from last cycle's means this is its first cycle: count restarts at zero.
   assign tmo_elapsed = (state == state_d) ? tmo_cnt : '0;
   assign tmo_hit     = busy && (tmo_elapsed == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         state_d <= IDLE;
         tmo_cnt <= '0;
      end else begin
         state_d <= state;
         tmo_cnt <= busy ? tmo_elapsed + 1'b1 : '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // NOTE: non-blocking assignments only, so every branch below reads the pre-edge register values.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         // NOTE: payload registers are reset as well, so the bus shows all zeros while in reset.
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rsp_valid  <= 1'b0;
         rsp_write  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_resp   <= 2'b00;
      end else if (tmo_hit) begin
         // Recovery abort: drop everything and report a decode error to the command side.
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         rsp_resp   <= 2'b11;
         rsp_valid  <= 1'b1;
         state      <= RSP;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     awaddr_q   <= BASE_ADDR + cmd_addr;
                     wdata_q    <= cmd_wdata;
                     wstrb_q    <= cmd_wstrb;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     aw_done    <= 1'b0;
                     w_done     <= 1'b0;
                     state      <= WR_REQ;
                  end else begin
                     araddr_q   <= BASE_ADDR + cmd_addr;
                     ar_valid_q <= 1'b1;
                     state      <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               // Address and data channels retire independently; move on once both have.
               if (aw_valid_q && axi.awready) begin
                  aw_valid_q <= 1'b0;
                  aw_done    <= 1'b1;
               end
               if (w_valid_q && axi.wready) begin
                  w_valid_q <= 1'b0;
                  w_done    <= 1'b1;
               end
               if (aw_done && w_done) begin
                  b_ready_q <= 1'b1;
                  state     <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi.bvalid && b_ready_q) begin
                  b_ready_q <= 1'b0;
                  rsp_resp  <= axi.bresp;
                  rsp_write <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end
            end
            RD_REQ: begin
               if (ar_valid_q && axi.arready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axi.rvalid && r_ready_q) begin
                  r_ready_q <= 1'b0;
                  rsp_rdata <= axi.rdata;
                  rsp_resp  <= axi.rresp;
                  rsp_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
